// File: rtl/uart_keyboard.sv
// uart_keyboard: 8N1 serial receiver feeding a small keycode FIFO.
// The head byte is presented as an Apple-style keycode {1'b1, ascii[6:0]},
// or 8'h00 when nothing is queued. A rising edge on keystrobe pops the head.
module uart_keyboard #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       keystrobe,
    output logic [7:0] keycode,
    output logic       overrun,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic          rx_meta_q, rx_meta_d;
    logic          rxs_q, rxs_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          ks_q, ks_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic push_req;
    logic fe_req;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;

    // Two-stage synchronizer for the asynchronous serial line, idle-high.
    always_comb begin
        rx_meta_d = rx;
        rxs_d     = rx_meta_q;
    end

    // Receiver FSM: mid-bit sampling from the start-bit centre, LSB first.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        fe_req    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    if (!rxs_q) begin
                        state_d   = ST_DATA;
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push_req = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        fe_req  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO status and push/pop arbitration; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = keystrobe & ~ks_q & ~fifo_empty;
        push       = push_req & (~fifo_full | pop);
        overrun_d  = push_req & fifo_full & ~pop;
        frame_err_d = fe_req;
        ks_d       = keystrobe;
    end

    // FIFO storage and pointer updates.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Keycode decoded purely from registered FIFO state.
    always_comb begin
        if (fifo_empty) begin
            keycode = 8'h00;
        end else begin
            keycode = {1'b1, mem_q[rd_ptr_q[AW-1:0]][6:0]};
        end
    end

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

    // State registers; ks_q resets high so a strobe held through reset does not pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            ks_q        <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            ks_q        <= ks_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: doc/uart_keyboard.md
# uart_keyboard

Serial keyboard front-end feeding the CPU16 `keycode`/`keystrobe` port. Receives 8N1 asynchronous serial bytes on `rx` and queues them in a small FIFO. It presents the head byte as an Apple-style keycode: bit 7 set means a key is available, and bits 6:0 carry the ASCII code, so space = 8'hA0. The CPU consumes the head entry by raising `keystrobe`.

## Interface
- `CLKS_PER_BIT`, 16, clk cycles per serial bit; even, ≥ 4.
- `FIFO_DEPTH`, 4, queue entries; power of two, ≥ 2.

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low; one clock, asynchronous active-low reset
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `keystrobe`  in  1  CPU acknowledge; rising edge pops the head entry
- `keycode`  out  8  `{1'b1, head[6:0]}` when FIFO non-empty, else 8'h00
- `overrun`  out  1  one-cycle pulse when a received byte is dropped because the FIFO is full
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low

## Operation
- **rx synchronizer:** 2 flops, reset to 1; all FSM decisions use the synced value `rxs`.
- **Receiver FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rxs`=0 → START, bit counter cleared.
  - START: at count CLKS_PER_BIT/2−1, sample. 0 → DATA, with counter and bit index cleared. 1 → IDLE (glitch rejected, no error).
  - DATA: every CLKS_PER_BIT cycles, sample into the shift register LSB first. After bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. 1 → push the byte and go to IDLE. 0 → `frame_err` pulse, byte discarded, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- **FIFO:** `FIFO_DEPTH` × 8 storage, read/write pointers of log2(DEPTH)+1 bits that wrap naturally. Full when MSBs differ and the rest match.
- **Pop:** taken on `keystrobe & ~ks_q`. `ks_q` is a registered copy of `keystrobe` and resets to 1, so a strobe already high when reset deasserts does not pop. Holding `keystrobe` high yields exactly one pop. A pop on an empty FIFO is ignored.
- **Push to a full FIFO:**
  - With no pop the same cycle: byte dropped, `overrun` pulses, contents unchanged.
  - With a pop the same cycle: pop and push both take effect, no overrun.
- **Push and pop on a non-empty, non-full FIFO:** both take effect and the count is unchanged.
- **Stored data:** the full 8 bits are stored. Bit 7 of the received byte is discarded at the output.

## Timing
- **Reset values:** `keycode`=8'h00, `overrun`=0, `frame_err`=0. FSM in IDLE, FIFO empty, counters 0.
- **Reset mid-frame:** the frame is aborted and the FIFO is flushed. After reset the FSM waits in IDLE. A low `rx` at reset release is treated as a start bit.
- **Push:** occurs at the stop-bit sample. `keycode` reflects the new byte on the next cycle if the FIFO was empty.
- **Rx-to-keycode latency:** from the `rx` falling edge of the start bit to `keycode` valid is 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles, ±1. With the defaults this is 155.
- **Pop-to-keycode latency:** `keycode` updates on the cycle after the `keystrobe` rising edge. It becomes 8'h00 if that pop emptied the FIFO.
- **Output paths:** `keycode` is decoded only from registered state. There is no combinational path from `rx` or `keystrobe`.
- **Back-to-back frames:** a start bit immediately following the stop-bit sample is accepted. The receiver re-arms in the cycle after STOP.

## Test plan
- **Single byte:** reset, send 0x20 at CLKS_PER_BIT=16.
  - `keycode` goes to 8'hA0 at cycle 155 ±1 and stays there.
  - Pulse `keystrobe` for 3 cycles → `keycode`=8'h00 next cycle, exactly one pop.
- **Ordering and overrun:** send 0x41, 0x42, 0x43, 0x44, 0x45 with no strobe.
  - `overrun` pulses once, on the fifth byte.
  - Successive strobes yield C1, C2, C3, C4, then 00.
- **Framing:** send 0x31 with stop bit = 0, then hold `rx` low for 40 bit-times, then send 0x32.
  - One `frame_err` pulse and no push for 0x31.
  - Then `keycode`=8'hB2.
- **Simultaneous events:** with the FIFO full, raise `keystrobe` in the same cycle as a stop-bit push.
  - No `overrun`, count stays 4.
  - The new byte appears last in pop order.
- **Glitch and reset:**
  - A 3-cycle low pulse on `rx` → no push, no `frame_err`.
  - Assert `reset` mid-DATA with 2 bytes queued → `keycode`=00 immediately and the FIFO is empty.
  - `keystrobe` held high through reset release causes no pop.
